sha256_id_arbiter: RTL and testbench
====================================

Name: sha256_id_arbiter

Overview:
- Shares the single packet-ID stream of the SHA-256 accelerator between NUM_REQ requesters (e.g. message builder, hash engine, validator).
- Round-robin arbitration.
- Each accepted input ID goes to exactly one granted requester through a registered, per-requester valid/ready output.
- Sits between the packet-ID issuer and the consumers of packet IDs.

Parameters:
- ID_W, 6, width of packet ID.
- NUM_REQ, 3, number of requesters; legal range 2..8.
- IDX_W, $clog2(NUM_REQ), width of grant index; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; low freezes block.
- sync_rst  input  1  synchronous localised reset, active-high.
- id_in  input  ID_W  packet ID from issuer.
- id_in_last  input  1  last flag accompanying id_in.
- id_in_valid  input  1  id_in valid.
- id_in_ready  output  1  arbiter accepts id_in (combinational).
- req  input  NUM_REQ  per-requester ID request, level.
- id_out  output  ID_W  registered ID, shared by all requesters.
- id_out_last  output  1  registered last flag.
- id_out_valid  output  NUM_REQ  one-hot valid to granted requester.
- id_out_ready  input  NUM_REQ  per-requester ready.
- grant_idx  output  IDX_W  index of current/last grantee.
- busy  output  1  high while in HOLD.

Behaviour:
- Reset values (nrst low async, or sync_rst high at clock edge; sync_rst has priority over en):
  - state=ARB, id_out=0, id_out_last=0, id_out_valid=0, grant_idx=0, busy=0.
  - Round-robin pointer ptr=NUM_REQ-1, so requester 0 has first priority.
- States:
  - ARB: no ID held.
  - HOLD: ID held for the winner.
- ARB:
  - id_in_ready = en & |req.
  - On id_in_valid & id_in_ready: winner = first set bit of req searching ptr+1, ptr+2, … modulo NUM_REQ.
  - Next edge registers id_out<=id_in, id_out_last<=id_in_last, id_out_valid<=onehot(winner), grant_idx<=winner, busy<=1, state<=HOLD.
  - No req, or no id_in_valid: stay in ARB, nothing consumed.
- HOLD:
  - id_in_ready=0.
  - id_out/id_out_last/id_out_valid stable until id_out_ready[grant_idx]=1 at an edge; ready of non-granted requesters is ignored.
  - On that handshake: id_out_valid<=0, busy<=0, ptr<=grant_idx, state<=ARB.
  - id_out and grant_idx retain their values.
- Latency: input handshake at edge N gives id_out_valid high after N. Consumer ready at edge N+1 allows next input acceptance in the cycle after N+1. Maximum throughput is 1 ID per 2 cycles.
- Withdrawn request: req dropping in HOLD does not cancel the grant; the ID stays offered until taken.
- Simultaneous requests: strictly round-robin. With all requesters permanently requesting, grants cycle 0,1,2,0,…
- Pointer wrap: index NUM_REQ-1 wraps to 0.
- en low: all registers hold, including id_out_valid. id_in_ready=0. Handshakes on id_out_ready are ignored (no state change).
- Reset mid-HOLD: the held ID is discarded; the requester sees id_out_valid fall without a handshake.
- Unknown/illegal state encoding: return to ARB next cycle.
- The arbiter does not modify the ID value; no ID is duplicated or dropped except on reset.

Optional Feature:
- Macro SHA256_ID_ARB_STATS_EN.
- Defined:
  - Adds output grant_count, width NUM_REQ*8: per-requester 8-bit counters.
  - Each counter increments on every completed output handshake to that requester and wraps 255->0.
  - Reset to 0 by nrst/sync_rst; frozen while en low.
- Undefined: port and counters absent; the rest of the behaviour is identical.

Test Plan:
- Reset default: after nrst, req=3'b111, id_in=6'd5 valid → id_in_ready=1. Next cycle id_out=5, id_out_valid=3'b001, grant_idx=0, busy=1.
- Round-robin: req=3'b111, all id_out_ready=1, id_in=10,11,12,13 → grants 0,1,2,0; id_out values 10,11,12,13; one ID per 2 cycles.
- Skip idle requester: req=3'b101, ptr after grant to 0 → next grant 2, then 0. Requester 1 never sees valid.
- Backpressure: grantee 1 holds id_out_ready[1]=0 for 5 cycles while id_in_valid=1 → id_in_ready=0 throughout, id_out stable. Other requesters' ready ignored. Release → valid clears, ARB resumes.
- en/sync_rst: en=0 in HOLD for 3 cycles → outputs frozen, ready ignored. Then sync_rst=1 → id_out_valid=0, id_out=0, state ARB, grant order restarts at 0.
- With SHA256_ID_ARB_STATS_EN: 300 handshakes to requester 2 → grant_count[23:16]=44, others 0.

Source files
------------

// File: rtl/sha256_id_arbiter.sv
// Round-robin distributor of the SHA-256 packet-ID stream to NUM_REQ consumers.
// Define SHA256_ID_ARB_STATS_EN to add per-requester 8-bit handshake counters (grant_count).
module sha256_id_arbiter #(
  parameter  int ID_W    = 6,
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               sync_rst,
  input  logic [ID_W-1:0]    id_in,
  input  logic               id_in_last,
  input  logic               id_in_valid,
  output logic               id_in_ready,
  input  logic [NUM_REQ-1:0] req,
  output logic [ID_W-1:0]    id_out,
  output logic               id_out_last,
  output logic [NUM_REQ-1:0] id_out_valid,
  input  logic [NUM_REQ-1:0] id_out_ready,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy
`ifdef SHA256_ID_ARB_STATS_EN
  ,
  output logic [NUM_REQ*8-1:0] grant_count
`endif
);

  typedef enum logic [1:0] {
    ST_ARB  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W:0]     cand_s;
  logic               accept_s;
  logic               take_s;
  logic               state_legal_s;

  assign accept_s      = id_in_valid & id_in_ready;
  assign take_s        = (state_r == ST_HOLD) & en & id_out_ready[grant_idx];
  assign state_legal_s = (state_r == ST_ARB) | (state_r == ST_HOLD);

  // Round-robin search from ptr+1 upward; the lowest offset is visited last so it wins.
  always_comb begin
    winner_s = '0;
    cand_s   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_s   = {1'b0, ptr_r} + (IDX_W+1)'(i);
      cand_s   = (cand_s >= (IDX_W+1)'(NUM_REQ)) ? cand_s - (IDX_W+1)'(NUM_REQ) : cand_s;
      winner_s = req[cand_s[IDX_W-1:0]] ? cand_s[IDX_W-1:0] : winner_s;
    end
  end

  // State register; an illegal encoding recovers to ARB even while frozen.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= ST_ARB;
    end else if (sync_rst) begin
      state_r <= ST_ARB;
    end else if (en || !state_legal_s) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = ST_ARB;
    case (state_r)
      ST_ARB:  state_nxt_s = accept_s ? ST_HOLD : ST_ARB;
      ST_HOLD: state_nxt_s = take_s ? ST_ARB : ST_HOLD;
      default: state_nxt_s = ST_ARB;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    id_in_ready = (state_r == ST_ARB) & en & (|req);
    busy        = (state_r == ST_HOLD);
  end

  // Held ID, one-hot valid, grant index and round-robin pointer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      id_out       <= '0;
      id_out_last  <= 1'b0;
      id_out_valid <= '0;
      grant_idx    <= '0;
      ptr_r        <= IDX_W'(NUM_REQ - 1);
    end else if (sync_rst) begin
      id_out       <= '0;
      id_out_last  <= 1'b0;
      id_out_valid <= '0;
      grant_idx    <= '0;
      ptr_r        <= IDX_W'(NUM_REQ - 1);
    end else if (en) begin
      if (accept_s) begin
        id_out       <= id_in;
        id_out_last  <= id_in_last;
        id_out_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
        grant_idx    <= winner_s;
      end else if (take_s) begin
        id_out_valid <= '0;
        ptr_r        <= grant_idx;
      end
    end
  end

`ifdef SHA256_ID_ARB_STATS_EN
  // Per-requester completed-handshake counters, wrapping at 8 bits.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      grant_count <= '0;
    end else if (sync_rst) begin
      grant_count <= '0;
    end else if (take_s) begin
      grant_count[int'(grant_idx)*8 +: 8] <= grant_count[int'(grant_idx)*8 +: 8] + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_id_arbiter.sv
// Randomised self-checking bench for sha256_id_arbiter against a transaction-level model.
module tb_sha256_id_arbiter;
  localparam int ID_W    = 6;
  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 2;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0;
  logic sync_rst = 1'b0;
  logic [ID_W-1:0] id_in = '0;
  logic id_in_last = 1'b0;
  logic id_in_valid = 1'b0;
  logic id_in_ready;
  logic [NUM_REQ-1:0] req = '0;
  logic [ID_W-1:0] id_out;
  logic id_out_last;
  logic [NUM_REQ-1:0] id_out_valid;
  logic [NUM_REQ-1:0] id_out_ready = '0;
  logic [IDX_W-1:0] grant_idx;
  logic busy;
`ifdef SHA256_ID_ARB_STATS_EN
  logic [NUM_REQ*8-1:0] grant_count;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: one held transaction, a last-served index, per-requester counts.
  bit m_hold;
  int m_ptr, m_gidx;
  logic [ID_W-1:0] m_id;
  logic m_last;
  logic [NUM_REQ-1:0] m_vld;
  int m_cnt[NUM_REQ];

  sha256_id_arbiter #(.ID_W(ID_W), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
    .id_in(id_in), .id_in_last(id_in_last), .id_in_valid(id_in_valid), .id_in_ready(id_in_ready),
    .req(req), .id_out(id_out), .id_out_last(id_out_last), .id_out_valid(id_out_valid),
    .id_out_ready(id_out_ready), .grant_idx(grant_idx), .busy(busy)
`ifdef SHA256_ID_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int m_winner(input logic [NUM_REQ-1:0] r);
    for (int i = 1; i <= NUM_REQ; i++) begin
      int k;
      k = (m_ptr + i) % NUM_REQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic m_ready();
    return en && !m_hold && (req != '0);
  endfunction

  task automatic m_reset();
    m_hold = 1'b0; m_ptr = NUM_REQ - 1; m_gidx = 0;
    m_id = '0; m_last = 1'b0; m_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
  endtask

  // Advance the model on the current inputs, then clock the DUT and settle.
  task automatic step();
    if (sync_rst) begin
      m_reset();
    end else if (en) begin
      if (!m_hold && id_in_valid && req != '0) begin
        m_gidx = m_winner(req);
        m_id = id_in; m_last = id_in_last;
        m_vld = '0; m_vld[m_gidx] = 1'b1;
        m_hold = 1'b1;
      end else if (m_hold && id_out_ready[m_gidx]) begin
        m_vld = '0; m_hold = 1'b0; m_ptr = m_gidx;
        m_cnt[m_gidx] = (m_cnt[m_gidx] + 1) % 256;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_sync_reset();
    sync_rst = 1'b1; en = 1'b1; step(); sync_rst = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b1; #12;
    tests++;
    if ({id_out, id_out_last, id_out_valid, grant_idx, busy} !== 13'd0) begin
      fails++; $display("FAIL reset_outputs got=%h exp=0", {id_out, id_out_last, id_out_valid, grant_idx, busy});
    end
    @(negedge clk); nrst = 1'b1; m_reset();
    req = 3'b111; id_in = 6'd5; id_in_valid = 1'b1; #1;
    tests++;
    if (id_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", id_in_ready); end
    step();
    tests++;
    if ({id_out, id_out_valid, grant_idx, busy} !== {6'd5, 3'b001, 2'd0, 1'b1}) begin
      fails++; $display("FAIL reset_first_grant got id=%0d vld=%b gidx=%0d busy=%b exp id=5 vld=001 gidx=0 busy=1",
                        id_out, id_out_valid, grant_idx, busy);
    end
    id_in_valid = 1'b0; id_out_ready = 3'b001; step();
    tests++;
    if ({id_out_valid, busy} !== 4'b0000) begin fails++; $display("FAIL reset_release got vld=%b busy=%b exp 000/0", id_out_valid, busy); end
  endtask

  task automatic test_round_robin();
    int n, g[$], v[$];
    do_sync_reset();
    req = 3'b111; id_out_ready = 3'b111; id_in_valid = 1'b1; n = 0;
    for (int c = 0; c < 8; c++) begin
      id_in = 6'(10 + n); id_in_last = n[0]; #1;
      tests++;
      if (id_in_ready !== m_ready()) begin fails++; $display("FAIL rr_in_ready cyc=%0d got=%b exp=%b", c, id_in_ready, m_ready()); end
      if (m_ready()) n++;
      step();
      tests++;
      if ({id_out, id_out_last, id_out_valid, grant_idx, busy} !== {m_id, m_last, m_vld, IDX_W'(m_gidx), m_hold}) begin
        fails++; $display("FAIL rr_out cyc=%0d got=%h exp=%h", c, {id_out, id_out_last, id_out_valid, grant_idx, busy},
                          {m_id, m_last, m_vld, IDX_W'(m_gidx), m_hold});
      end
      if (id_out_valid != '0) begin g.push_back(int'(grant_idx)); v.push_back(int'(id_out)); end
    end
    tests++;
    if (g.size() != 4 || g[0] != 0 || g[1] != 1 || g[2] != 2 || g[3] != 0 ||
        v[0] != 10 || v[1] != 11 || v[2] != 12 || v[3] != 13) begin
      fails++; $display("FAIL rr_sequence got grants=%p ids=%p exp grants 0,1,2,0 ids 10..13", g, v);
    end
  endtask

  task automatic test_skip_idle();
    int g[$];
    bit saw1;
    do_sync_reset();
    req = 3'b101; id_out_ready = 3'b111; id_in_valid = 1'b1; saw1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      id_in = 6'($urandom); #1;
      step();
      tests++;
      if ({id_out, id_out_valid, grant_idx, busy} !== {m_id, m_vld, IDX_W'(m_gidx), m_hold}) begin
        fails++; $display("FAIL skip_out cyc=%0d got=%h exp=%h", c, {id_out, id_out_valid, grant_idx, busy},
                          {m_id, m_vld, IDX_W'(m_gidx), m_hold});
      end
      if (id_out_valid[1]) saw1 = 1'b1;
      if (id_out_valid != '0) g.push_back(int'(grant_idx));
    end
    tests++;
    if (saw1 || g.size() != 4 || g[0] != 0 || g[1] != 2 || g[2] != 0 || g[3] != 2) begin
      fails++; $display("FAIL skip_sequence got grants=%p saw1=%b exp 0,2,0,2 saw1=0", g, saw1);
    end
  endtask

  task automatic test_backpressure();
    logic [ID_W-1:0] held;
    do_sync_reset();
    req = 3'b010; id_in = 6'($urandom); held = id_in; id_in_valid = 1'b1; id_out_ready = 3'b000; #1;
    step();
    for (int c = 0; c < 5; c++) begin
      req = 3'($urandom); id_in = 6'($urandom); id_out_ready = 3'($urandom) & 3'b101; #1;
      tests++;
      if (id_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, id_in_ready); end
      step();
      tests++;
      if ({id_out, id_out_valid, grant_idx, busy} !== {held, 3'b010, 2'd1, 1'b1}) begin
        fails++; $display("FAIL bp_hold cyc=%0d got id=%0d vld=%b gidx=%0d exp id=%0d vld=010 gidx=1", c, id_out, id_out_valid, grant_idx, held);
      end
    end
    id_out_ready = 3'b010; req = 3'b111; step();
    tests++;
    if ({id_out_valid, busy, id_in_ready, id_out, grant_idx} !== {3'b000, 1'b0, 1'b1, held, 2'd1}) begin
      fails++; $display("FAIL bp_release got vld=%b busy=%b rdy=%b id=%0d gidx=%0d exp 000/0/1 id=%0d gidx=1",
                        id_out_valid, busy, id_in_ready, id_out, grant_idx, held);
    end
  endtask

  task automatic test_en_sync_rst();
    do_sync_reset();
    req = 3'b111; id_in = 6'd33; id_in_valid = 1'b1; id_out_ready = 3'b000; #1;
    step();
    en = 1'b0; id_out_ready = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (id_in_ready !== 1'b0) begin fails++; $display("FAIL en_in_ready cyc=%0d got=%b exp=0", c, id_in_ready); end
      step();
      tests++;
      if ({id_out, id_out_valid, grant_idx, busy} !== {6'd33, 3'b001, 2'd0, 1'b1}) begin
        fails++; $display("FAIL en_frozen cyc=%0d got id=%0d vld=%b busy=%b exp id=33 vld=001 busy=1", c, id_out, id_out_valid, busy);
      end
    end
    sync_rst = 1'b1; step(); sync_rst = 1'b0;
    tests++;
    if ({id_out, id_out_valid, grant_idx, busy} !== 12'd0) begin
      fails++; $display("FAIL srst_clear got id=%0d vld=%b gidx=%0d busy=%b exp all 0", id_out, id_out_valid, grant_idx, busy);
    end
    en = 1'b1; id_out_ready = 3'b000; id_in = 6'd7; step();
    tests++;
    if ({id_out, id_out_valid, grant_idx} !== {6'd7, 3'b001, 2'd0}) begin
      fails++; $display("FAIL srst_restart got id=%0d vld=%b gidx=%0d exp id=7 vld=001 gidx=0", id_out, id_out_valid, grant_idx);
    end
  endtask

  task automatic test_random();
    do_sync_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      sync_rst = ($urandom_range(0, 39) == 0);
      req = 3'($urandom); id_in = 6'($urandom); id_in_last = 1'($urandom);
      id_in_valid = 1'($urandom); id_out_ready = 3'($urandom); #1;
      tests++;
      if (id_in_ready !== m_ready()) begin fails++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, id_in_ready, m_ready()); end
      step();
      tests++;
      if ({id_out, id_out_last, id_out_valid, grant_idx, busy} !== {m_id, m_last, m_vld, IDX_W'(m_gidx), m_hold}) begin
        fails++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", c, {id_out, id_out_last, id_out_valid, grant_idx, busy},
                          {m_id, m_last, m_vld, IDX_W'(m_gidx), m_hold});
      end
`ifdef SHA256_ID_ARB_STATS_EN
      tests++;
      if (grant_count !== {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])}) begin
        fails++; $display("FAIL rand_count cyc=%0d got=%h exp=%0d/%0d/%0d", c, grant_count, m_cnt[2], m_cnt[1], m_cnt[0]);
      end
`endif
    end
    sync_rst = 1'b0; en = 1'b1;
  endtask

`ifdef SHA256_ID_ARB_STATS_EN
  task automatic test_stats();
    do_sync_reset();
    req = 3'b100; id_out_ready = 3'b111; id_in_valid = 1'b1;
    for (int c = 0; c < 600; c++) begin id_in = 6'($urandom); step(); end
    tests++;
    if (grant_count !== {8'd44, 8'd0, 8'd0}) begin fails++; $display("FAIL stats_wrap got=%h exp=2c0000", grant_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_backpressure();
    test_en_sync_rst();
    test_random();
`ifdef SHA256_ID_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
